// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_pkg
// Purpose  : Shared widths and the IRAM write-entry type for the sort blocks.
// Revision : 1.0 - initial release
// ============================================================================
package sort_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NREQ   = 2;

    // One buffered IRAM write: word address plus write data
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wentry_t;

endpackage
`default_nettype wire

// File: rtl/sort_wfifo.sv
`default_nettype none
// ============================================================================
// Module   : sort_wfifo
// Purpose  : Per-requester synchronous write buffer. A push to a full buffer
//            is accepted only when the head is popped in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sort_wfifo
    import sort_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wentry_t                    push_entry,
    input  logic                       pop,
    output wentry_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    wentry_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_do_pop;
    logic                 w_do_push;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop & ~w_empty;
    // A full buffer still takes a push when its head leaves in the same cycle
    assign w_do_push = push & (~w_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/iram_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : iram_wr_arb
// Purpose  : Merges the write streams of two sort engines into one shared
//            IRAM write port through per-requester buffers and a round-robin
//            arbiter. Tracks overflow and overall completion.
//            The reset input is expected to be released synchronously to clk.
// Revision : 1.0 - initial release
// ============================================================================
module iram_wr_arb
    import sort_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_A,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_D,
    input  logic [NREQ-1:0]               req_done,
    output logic                          IRAM_valid,
    output logic [ADDR_W:0]               IRAM_A,
    output logic [DATA_W-1:0]             IRAM_D,
    output logic [NREQ-1:0]               ovf,
    output logic                          done
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    wentry_t [NREQ-1:0]              w_head;
    logic    [NREQ-1:0]              w_empty;
    logic    [NREQ-1:0]              w_full;
    logic    [NREQ-1:0]              w_pop;
    logic    [NREQ-1:0]              w_drop;
    logic    [NREQ-1:0][c_cnt_w-1:0] w_count;
    logic                            w_grant_vld;
    logic                            w_grant_idx;
    logic                            w_all_empty;
    wentry_t                         w_sel;

    logic                            r_iram_valid;
    logic    [ADDR_W:0]              r_iram_a;
    logic    [DATA_W-1:0]            r_iram_d;
    logic    [NREQ-1:0]              r_ovf;
    logic                            r_done;
    logic    [NREQ-1:0]              r_done_seen;
    logic                            r_rr_prio;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
            sort_wfifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk        (clk),
                .reset      (reset),
                .push       (req_valid[gi]),
                .push_entry ({req_A[gi], req_D[gi]}),
                .pop        (w_pop[gi]),
                .head       (w_head[gi]),
                .full       (w_full[gi]),
                .empty      (w_empty[gi]),
                .count      (w_count[gi])
            );
            // Write lost: buffer full and its head is not leaving this cycle
            assign w_drop[gi] = req_valid[gi] & w_full[gi] & ~w_pop[gi];
        end
    endgenerate

    assign w_all_empty = (w_count == '0);

    // Two-way round robin: contention goes to r_rr_prio, otherwise the lone
    // non-empty buffer wins
    always_comb begin
        w_grant_vld = |(~w_empty);
        w_grant_idx = 1'b0;
        if (&(~w_empty)) begin
            w_grant_idx = r_rr_prio;
        end else begin
            w_grant_idx = ~w_empty[1];
        end
        w_pop = '0;
        if (w_grant_vld) begin
            w_pop[w_grant_idx] = 1'b1;
        end
        w_sel = w_head[w_grant_idx];
    end

    // Registered IRAM port, sticky flags and round-robin priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iram_valid <= 1'b0;
            r_iram_a     <= '0;
            r_iram_d     <= '0;
            r_ovf        <= '0;
            r_done       <= 1'b0;
            r_done_seen  <= '0;
            r_rr_prio    <= 1'b0;
        end else begin
            r_iram_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_iram_a  <= {w_grant_idx, w_sel.addr};
                r_iram_d  <= w_sel.data;
                r_rr_prio <= ~w_grant_idx;
            end
            r_ovf       <= r_ovf | w_drop;
            r_done_seen <= r_done_seen | req_done;
            // Completion needs an idle cycle, so it never coincides with a write
            if ((&r_done_seen) && w_all_empty && !w_grant_vld) begin
                r_done <= 1'b1;
            end
        end
    end

    assign IRAM_valid = r_iram_valid;
    assign IRAM_A     = r_iram_a;
    assign IRAM_D     = r_iram_d;
    assign ovf        = r_ovf;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_iram_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_iram_wr_arb
// Purpose  : Self-checking bench for iram_wr_arb with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iram_wr_arb;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0][3:0] req_A;
    logic [1:0][7:0] req_D;
    logic [1:0]      req_done;
    logic            IRAM_valid;
    logic [4:0]      IRAM_A;
    logic [7:0]      IRAM_D;
    logic [1:0]      ovf;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [11:0] mq [2][$];
    logic        m_prio;
    logic [1:0]  m_seen;
    logic [1:0]  m_ovf;
    logic        m_done;
    logic        m_valid;
    logic [4:0]  m_A;
    logic [7:0]  m_D;

    always #5 clk = ~clk;

    iram_wr_arb #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_A      (req_A),
        .req_D      (req_D),
        .req_done   (req_done),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .ovf        (ovf),
        .done       (done)
    );

    task automatic model_clear();
        mq[0].delete();
        mq[1].delete();
        m_prio  = 1'b0;
        m_seen  = 2'b00;
        m_ovf   = 2'b00;
        m_done  = 1'b0;
        m_valid = 1'b0;
        m_A     = '0;
        m_D     = '0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_A     = '0;
        req_D     = '0;
        req_done  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model.
    task automatic step(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] dn);
        int          g;
        logic [11:0] e;
        req_valid = v;
        req_A[0]  = a0;
        req_A[1]  = a1;
        req_D[0]  = d0;
        req_D[1]  = d1;
        req_done  = dn;
        @(posedge clk);
        g = -1;
        if (mq[0].size() > 0 && mq[1].size() > 0) g = int'(m_prio);
        else if (mq[0].size() > 0)                 g = 0;
        else if (mq[1].size() > 0)                 g = 1;
        if (g < 0 && m_seen == 2'b11) m_done = 1'b1;
        if (g >= 0) begin
            e       = mq[g].pop_front();
            m_valid = 1'b1;
            m_A     = {g[0], e[11:8]};
            m_D     = e[7:0];
            m_prio  = (g == 0);
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (v[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(i == 0 ? {a0, d0} : {a1, d1});
                else                      m_ovf[i] = 1'b1;
            end
        end
        m_seen = m_seen | dn;
        #1;
        req_valid = '0;
        req_done  = '0;
    endtask

    task automatic idle();
        step(2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (IRAM_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IRAM_valid); end
        n_tests++;
        if (IRAM_A !== 5'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", IRAM_A); end
        n_tests++;
        if (IRAM_D !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", IRAM_D); end
        n_tests++;
        if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b expected 00", ovf); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_single_push();
        do_reset();
        step(2'b01, 4'h3, 4'h0, 8'h5A, 8'h00, 2'b00);
        n_tests++;
        if (IRAM_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got valid %b expected 0", IRAM_valid); end
        idle();
        n_tests++;
        if ({IRAM_valid, IRAM_A, IRAM_D} !== {1'b1, 5'h03, 8'h5A}) begin
            n_fail++;
            $display("FAIL single_write: got v=%b A=%h D=%h expected v=1 A=03 D=5a", IRAM_valid, IRAM_A, IRAM_D);
        end
        idle();
        n_tests++;
        if ({IRAM_valid, IRAM_A, IRAM_D} !== {1'b0, 5'h03, 8'h5A}) begin
            n_fail++;
            $display("FAIL single_hold: got v=%b A=%h D=%h expected v=0 A=03 D=5a", IRAM_valid, IRAM_A, IRAM_D);
        end
    endtask

    task automatic test_interleave();
        logic [12:0] got[$];
        logic [12:0] exp[$];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp.push_back({1'b0, 4'(k), 8'(8'h10 + k)});
            exp.push_back({1'b1, 4'(k + 8), 8'(8'h20 + k)});
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 4) step(2'b11, 4'(k), 4'(k + 8), 8'(8'h10 + k), 8'(8'h20 + k), 2'b00);
            else       idle();
            if (IRAM_valid) got.push_back({IRAM_A, IRAM_D});
        end
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL interleave_count: got %0d writes expected %0d", got.size(), exp.size());
        end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            n_tests++;
            if (got[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL interleave_order[%0d]: got %h expected %h", k, got[k], exp[k]);
            end
        end
        n_tests++;
        if (ovf !== 2'b00) begin n_fail++; $display("FAIL interleave_ovf: got %b expected 00", ovf); end
    endtask

    task automatic test_overflow();
        logic [7:0] got0[$];
        logic [7:0] got1[$];
        logic [7:0] exp0[$];
        logic [7:0] exp1[$];
        do_reset();
        for (int k = 0; k < 10; k++) if (k != 8) exp0.push_back(8'(8'h30 + k));
        for (int k = 0; k < 5; k++) exp1.push_back(8'(8'h40 + k));
        for (int k = 0; k < 24; k++) begin
            if (k < 10) step({(k % 2 == 0), 1'b1}, 4'(k), 4'(k), 8'(8'h30 + k), 8'(8'h40 + k / 2), 2'b00);
            else        idle();
            if (IRAM_valid) begin
                if (IRAM_A[4]) got1.push_back(IRAM_D);
                else           got0.push_back(IRAM_D);
            end
            if (k == 7) begin
                n_tests++;
                if (ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_before_drop: got %b expected 00", ovf); end
            end
            if (k == 8) begin
                n_tests++;
                if (ovf !== 2'b01) begin n_fail++; $display("FAIL ovf_at_drop: got %b expected 01", ovf); end
            end
        end
        n_tests++;
        if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            n_fail++;
            $display("FAIL ovf_counts: got %0d/%0d writes expected %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        for (int k = 0; k < exp0.size() && k < got0.size(); k++) begin
            n_tests++;
            if (got0[k] !== exp0[k]) begin n_fail++; $display("FAIL ovf_req0[%0d]: got %h expected %h", k, got0[k], exp0[k]); end
        end
        for (int k = 0; k < exp1.size() && k < got1.size(); k++) begin
            n_tests++;
            if (got1[k] !== exp1[k]) begin n_fail++; $display("FAIL ovf_req1[%0d]: got %h expected %h", k, got1[k], exp1[k]); end
        end
        n_tests++;
        if (ovf !== 2'b01) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 01", ovf); end
    endtask

    task automatic test_done();
        int last_v  = 0;
        int first_d = 0;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            case (k)
                1:       step(2'b11, 4'h1, 4'h2, 8'hA1, 8'hB1, 2'b00);
                2:       step(2'b01, 4'h3, 4'h0, 8'hA2, 8'h00, 2'b01);
                3:       step(2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b10);
                default: idle();
            endcase
            if (IRAM_valid) last_v = k;
            if (done && first_d == 0) first_d = k;
            n_tests++;
            if (done && IRAM_valid) begin
                n_fail++;
                $display("FAIL done_with_write at edge %0d: got done=1 valid=1 expected not both", k);
            end
        end
        n_tests++;
        if (last_v != 4) begin n_fail++; $display("FAIL done_last_write: got edge %0d expected 4", last_v); end
        n_tests++;
        if (first_d != 5) begin n_fail++; $display("FAIL done_rise: got edge %0d expected 5", first_d); end
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %b expected 1", done); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        step(2'b11, 4'h1, 4'h2, 8'h11, 8'h21, 2'b00);
        step(2'b01, 4'h3, 4'h0, 8'h12, 8'h00, 2'b00);
        step(2'b11, 4'h4, 4'h5, 8'h13, 8'h22, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({IRAM_valid, IRAM_A, IRAM_D, ovf, done} !== 17'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got v=%b A=%h D=%h ovf=%b done=%b expected all 0", IRAM_valid, IRAM_A, IRAM_D, ovf, done);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (IRAM_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_held: got valid %b expected 0", IRAM_valid); end
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            idle();
            n_tests++;
            if (IRAM_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale[%0d]: got valid %b expected 0", k, IRAM_valid); end
        end
        step(2'b10, 4'h0, 4'h5, 8'h00, 8'h77, 2'b00);
        n_tests++;
        if (IRAM_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_push_latency: got valid %b expected 0", IRAM_valid); end
        idle();
        n_tests++;
        if ({IRAM_valid, IRAM_A, IRAM_D} !== {1'b1, 5'h15, 8'h77}) begin
            n_fail++;
            $display("FAIL midreset_new_write: got v=%b A=%h D=%h expected v=1 A=15 D=77", IRAM_valid, IRAM_A, IRAM_D);
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic [1:0] dn;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            v[0]  = ($urandom_range(0, 9) < 6);
            v[1]  = ($urandom_range(0, 9) < 5);
            dn[0] = ($urandom_range(0, 59) == 0);
            dn[1] = ($urandom_range(0, 59) == 0);
            if (k >= 300) v = 2'b00;
            step(v, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), dn);
            n_tests++;
            if ({IRAM_valid, IRAM_A, IRAM_D, ovf, done} !== {m_valid, m_A, m_D, m_ovf, m_done}) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b A=%h D=%h ovf=%b done=%b expected v=%b A=%h D=%h ovf=%b done=%b",
                         k, IRAM_valid, IRAM_A, IRAM_D, ovf, done, m_valid, m_A, m_D, m_ovf, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_interleave();
        test_overflow();
        test_done();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
